// File: rtl/instr_fetch_unit.sv
// RV32 fetch stage: owns the PC, issues one req/gnt/rvalid fetch at a time and
// holds the fetched instruction for decode until the core retires it.
module instr_fetch_unit #(
    parameter int unsigned              DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]    RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  retire,
    input  logic                  PCSrc,
    input  logic [DATA_WIDTH-1:0] PCTarget,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic [6:0]            op,
    output logic [2:0]            funct3,
    output logic                  funct7,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PCPlus4,
    output logic                  misaligned
);

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc_plus4;

    assign pc_plus4 = pc_q + DATA_WIDTH'(4);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                if (en) state_d = REQ;
            end
            REQ: begin
                // A grant wins over a same-cycle disable: the request is already accepted.
                if (imem_gnt)  state_d = WAIT;
                else if (!en)  state_d = IDLE;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (retire && en) begin
                    if (!PCSrc) begin
                        pc_d    = pc_plus4;
                        state_d = REQ;
                    end else if (PCTarget[1:0] == 2'b00) begin
                        pc_d    = PCTarget;
                        state_d = REQ;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign misaligned  = (state_q == FAULT);
    assign instr       = instr_valid ? instr_q : NOP_INSTR;
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign op          = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[30];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a task-driven memory responder
// pushes expected fetches at grant time and pops them when instr_valid rises.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn, en, imem_req, imem_gnt, imem_rvalid, retire, PCSrc;
    logic        instr_valid, funct7, misaligned;
    logic [31:0] imem_addr, imem_rdata, PCTarget, instr, PC, PCPlus4;
    logic [6:0]  op;
    logic [2:0]  funct3;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;
    int last_valid   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    instr_fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .retire     (retire),
        .PCSrc      (PCSrc),
        .PCTarget   (PCTarget),
        .instr      (instr),
        .instr_valid(instr_valid),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_1A53;
    endfunction

    task automatic do_reset();
        rstn        = 1'b0;
        en          = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        retire      = 1'b0;
        PCSrc       = 1'b0;
        PCTarget    = 32'h0;
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (imem_req === 1'b1);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL req_timeout: imem_req=%b after %0d cycles, expected 1", imem_req, n);
        end
    endtask

    // Entered at a negedge in HOLD: pop the scoreboard and compare everything visible.
    task automatic check_hold();
        exp_t e;
        tests_run++;
        if (instr_valid !== 1'b1 || exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL hold_valid: instr_valid=%b queued=%0d, expected 1 and >0", instr_valid, exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        last_valid = cycle;
        tests_run++;
        if ({instr, PC, PCPlus4} !== {e.data, e.addr, e.addr + 32'd4}) begin
            tests_failed++;
            $display("FAIL hold_data: instr/PC/PCPlus4=%h/%h/%h, expected %h/%h/%h",
                     instr, PC, PCPlus4, e.data, e.addr, e.addr + 32'd4);
        end
        tests_run++;
        if ({op, funct3, funct7} !== {e.data[6:0], e.data[14:12], e.data[30]}) begin
            tests_failed++;
            $display("FAIL hold_decode: op/f3/f7=%h/%h/%b, expected %h/%h/%b",
                     op, funct3, funct7, e.data[6:0], e.data[14:12], e.data[30]);
        end
    endtask

    // Serve one fetch: grant after gd extra REQ cycles, respond rd cycles after grant.
    task automatic serve(input int gd, input int rd, input logic [31:0] exp_addr);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        tests_run++;
        if (imem_addr !== exp_addr) begin
            tests_failed++;
            $display("FAIL req_addr: imem_addr=%h, expected %h", imem_addr, exp_addr);
        end
        for (int i = 0; i < gd; i++) begin
            @(negedge clk);
            tests_run++;
            if ({imem_req, imem_addr} !== {1'b1, exp_addr}) begin
                tests_failed++;
                $display("FAIL req_stable: req/addr=%b/%h, expected 1/%h", imem_req, imem_addr, exp_addr);
            end
        end
        imem_gnt = 1'b1;
        exp_q.push_back('{addr: exp_addr, data: mem_word(exp_addr)});
        @(negedge clk);
        imem_gnt = 1'b0;
        for (int i = 1; i < rd; i++) @(negedge clk);
        tests_run++;
        if ({imem_req, instr_valid, instr} !== {2'b00, NOP}) begin
            tests_failed++;
            $display("FAIL wait_outputs: req/valid/instr=%b/%b/%h, expected 0/0/%h", imem_req, instr_valid, instr, NOP);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(exp_addr);
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        check_hold();
    endtask

    task automatic retire_instr(input logic src, input logic [31:0] target);
        retire   = 1'b1;
        PCSrc    = src;
        PCTarget = target;
        @(negedge clk);
        retire   = 1'b0;
        PCSrc    = 1'b0;
        PCTarget = 32'h0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({imem_req, instr_valid, misaligned, imem_addr, PC, PCPlus4, instr} !==
            {3'b000, 32'h0, 32'h0, 32'h4, NOP}) begin
            tests_failed++;
            $display("FAIL reset_state: req/valid/mis=%b%b%b addr=%h PC=%h PC4=%h instr=%h, expected 000 0 0 4 %h",
                     imem_req, instr_valid, misaligned, imem_addr, PC, PCPlus4, instr, NOP);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_en: imem_req=%b, expected 0", imem_req);
        end
    endtask

    task automatic test_basic();
        int prev;
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            prev = last_valid;
            serve(0, 1, 32'(4 * k));
            if (k > 0) begin
                tests_run++;
                if (last_valid - prev !== 3) begin
                    tests_failed++;
                    $display("FAIL valid_period: %0d cycles between instructions, expected 3", last_valid - prev);
                end
            end
            if (k < 2) retire_instr(1'b0, 32'h0);
        end
    endtask

    task automatic test_branch();
        retire_instr(1'b1, 32'h0000_0100);
        tests_run++;
        if ({imem_req, imem_addr, PC} !== {1'b1, 32'h100, 32'h100}) begin
            tests_failed++;
            $display("FAIL branch_target: req/addr/PC=%b/%h/%h, expected 1/100/100", imem_req, imem_addr, PC);
        end
        serve(0, 1, 32'h100);
        retire_instr(1'b0, 32'h0);
    endtask

    task automatic test_late();
        serve(2, 3, 32'h104);
        // Stray rvalid/gnt while holding must not disturb the held instruction.
        imem_rvalid = 1'b1;
        imem_gnt    = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        tests_run++;
        if ({instr_valid, instr, exp_q.size()} !== {1'b1, mem_word(32'h104), 32'd0}) begin
            tests_failed++;
            $display("FAIL single_capture: valid/instr/queued=%b/%h/%0d, expected 1/%h/0",
                     instr_valid, instr, exp_q.size(), mem_word(32'h104));
        end
        retire_instr(1'b0, 32'h0);
    endtask

    task automatic test_en_drop();
        en = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({imem_req, PC} !== {1'b0, 32'h108}) begin
            tests_failed++;
            $display("FAIL en_drop: req/PC=%b/%h, expected 0/108", imem_req, PC);
        end
        en = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h108}) begin
            tests_failed++;
            $display("FAIL en_resume: req/addr=%b/%h, expected 1/108", imem_req, imem_addr);
        end
        serve(1, 2, 32'h108);
        en = 1'b0;
        retire_instr(1'b0, 32'h0);
        tests_run++;
        if ({instr_valid, PC} !== {1'b1, 32'h108}) begin
            tests_failed++;
            $display("FAIL retire_no_en: valid/PC=%b/%h, expected 1/108", instr_valid, PC);
        end
        en = 1'b1;
        retire_instr(1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        serve(0, 1, 32'h10C);
        retire_instr(1'b1, 32'hFFFF_FFFC);
        serve(0, 1, 32'hFFFF_FFFC);
        tests_run++;
        if (PCPlus4 !== 32'h0) begin
            tests_failed++;
            $display("FAIL pc_wrap: PCPlus4=%h, expected 00000000", PCPlus4);
        end
        retire_instr(1'b0, 32'h0);
        serve(0, 1, 32'h0);
        retire_instr(1'b0, 32'h0);
    endtask

    task automatic test_misaligned();
        int bad = 0;
        serve(0, 1, 32'h4);
        retire_instr(1'b1, 32'h0000_0102);
        tests_run++;
        if ({misaligned, imem_req, instr_valid, instr, PC} !== {3'b100, NOP, 32'h4}) begin
            tests_failed++;
            $display("FAIL fault_entry: mis/req/valid=%b%b%b instr=%h PC=%h, expected 100 %h 4",
                     misaligned, imem_req, instr_valid, instr, PC, NOP);
        end
        imem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({misaligned, imem_req} !== 2'b10) bad++;
        end
        imem_gnt = 1'b0;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL fault_sticky: %0d cycles left FAULT or requested, expected 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        rstn = 1'b1;
        tests_run++;
        if (misaligned !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_cleared: misaligned=%b, expected 0", misaligned);
        end
        en = 1'b1;
        serve(0, 1, 32'h0);
        retire_instr(1'b1, 32'h200);
        wait_req(ok);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        #2 rstn = 1'b0;
        #1;
        tests_run++;
        if ({imem_req, instr_valid, misaligned, imem_addr, PC, instr} !== {3'b000, 32'h0, 32'h0, NOP}) begin
            tests_failed++;
            $display("FAIL async_reset: req/valid/mis=%b%b%b addr=%h PC=%h instr=%h, expected 000 0 0 %h",
                     imem_req, instr_valid, misaligned, imem_addr, PC, instr, NOP);
        end
        exp_q.delete();
        en = 1'b0;
        @(negedge clk);
        rstn        = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0BAD;
        @(negedge clk);
        imem_rvalid = 1'b0;
        tests_run++;
        if ({imem_req, instr_valid, instr} !== {2'b00, NOP}) begin
            tests_failed++;
            $display("FAIL late_rvalid: req/valid/instr=%b/%b/%h, expected 0/0/%h", imem_req, instr_valid, instr, NOP);
        end
        en = 1'b1;
        serve(0, 1, 32'h0);
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_late();
        test_en_drop();
        test_wrap();
        test_misaligned();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
